// File: rtl/ads8689_pkg.sv
// rtl/ads8689_pkg.sv - ADS8689 opcodes, register map, sequencer states and config word table
package ads8689_pkg;

    localparam logic [6:0] CMD_NOP  = 7'h00;
    localparam logic [6:0] CMD_RDHW = 7'h64;
    localparam logic [6:0] CMD_WRHW = 7'h68;

    localparam logic [8:0] DEV_ID_REG      = 9'h000;
    localparam logic [8:0] DATAOUT_CTL_REG = 9'h010;
    localparam logic [8:0] RANGE_SEL_REG   = 9'h014;

    localparam logic [5:0] FRAME_LEN = 6'd32;

    typedef enum logic [2:0] {
        IDLE, CFG_REQ, CFG_WAIT, VFY_REQ, VFY_WAIT, READY, RD_REQ, RD_WAIT
    } ads_state_e;

    function automatic logic [31:0] frame(input logic [6:0] cmd, input logic [8:0] addr,
                                          input logic [15:0] data);
        return {cmd, addr, data};
    endfunction

    // Even index writes the low half-word of a register, odd index the high half at addr+2.
    function automatic logic [31:0] cfg_word(input logic [3:0] idx, input logic [3:0] range_code);
        logic [8:0]  base;
        logic [15:0] data;
        case (idx[3:1])
            3'd0:    base = DEV_ID_REG;
            3'd2:    base = DATAOUT_CTL_REG;
            default: base = RANGE_SEL_REG;
        endcase
        data = (base == RANGE_SEL_REG && !idx[0]) ? {12'h000, range_code} : 16'h0000;
        return frame(CMD_WRHW, base + {7'd0, idx[0], 1'b0}, data);
    endfunction

endpackage

// File: rtl/ads_timeout_cnt.sv
// rtl/ads_timeout_cnt.sv - loadable down-counter with a one-cycle expire pulse
module ads_timeout_cnt #(
    parameter int W = 16
) (
    input  logic         clk_sys,
    input  logic         rst_sys_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && !load && (cnt == W'(1));

endmodule

// File: rtl/ads_cfg_seq.sv
// rtl/ads_cfg_seq.sv - ADS8689 configuration/readout sequencer; ADS_CFG_VERIFY_EN adds range readback
module ads_cfg_seq
    import ads8689_pkg::*;
#(
    parameter int          NUM_CFG    = 8,
    parameter logic [3:0]  RANGE_CODE = 4'h0,
    parameter logic [15:0] TIMEOUT    = 16'd1000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        start,
    input  logic        conv_req,
    input  logic        cmd_ready,
    input  logic        spi_done,
    input  logic [31:0] spi_rdata,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    output logic [5:0]  cmd_len,
    output logic        cmd_rd,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        overrun,
    output logic        sample_valid,
    output logic [15:0] sample_data
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CFG - 1);

    ads_state_e  state, nxt_state;
    logic [3:0]  idx, nxt_idx;
    logic        pend, nxt_pend;
    logic        nxt_cmd_valid, nxt_cmd_rd;
    logic [31:0] nxt_cmd_data;
    logic        nxt_cfg_done, nxt_cfg_err, nxt_overrun, nxt_sample_valid;
    logic [15:0] nxt_sample_data;
    logic        hs, in_req, in_wait, tmo_expire, restart;
    logic        unused_cfg;
`ifdef ADS_CFG_VERIFY_EN
    logic        vfy_phase, nxt_vfy_phase;
    logic [3:0]  retry_cnt, nxt_retry_cnt;
`endif

    assign hs         = cmd_valid && cmd_ready;
    assign in_req     = state inside {CFG_REQ, VFY_REQ, RD_REQ};
    assign in_wait    = state inside {CFG_WAIT, VFY_WAIT, RD_WAIT};
    assign restart    = start && (state == IDLE || state == READY);
    assign unused_cfg = ^{spi_rdata[15:0], MAX_RETRY != 0};

    ads_timeout_cnt #(.W(16)) u_tmo (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .load      (hs),
        .load_val  (TIMEOUT),
        .en        (in_wait),
        .expire    (tmo_expire)
    );

    always_comb begin
        nxt_state        = state;
        nxt_idx          = idx;
        nxt_pend         = pend;
        nxt_cmd_valid    = in_req && !hs;
        nxt_cmd_data     = cmd_data;
        nxt_cmd_rd       = cmd_rd;
        nxt_cfg_done     = cfg_done;
        nxt_cfg_err      = cfg_err;
        nxt_overrun      = overrun;
        nxt_sample_valid = 1'b0;
        nxt_sample_data  = sample_data;
`ifdef ADS_CFG_VERIFY_EN
        nxt_vfy_phase    = vfy_phase;
        nxt_retry_cnt    = retry_cnt;
`endif
        // Requests while busy go to the single pending slot; a second one is lost.
        if (conv_req && cfg_done && state != READY) begin
            if (pend) nxt_overrun = 1'b1;
            else      nxt_pend    = 1'b1;
        end

        case (state)
            IDLE: ;
            CFG_REQ: if (hs) nxt_state = CFG_WAIT;
            CFG_WAIT: begin
                if (spi_done) begin
                    nxt_idx = idx + 4'd1;
                    if (idx == LAST_IDX) begin
`ifdef ADS_CFG_VERIFY_EN
                        nxt_state     = VFY_REQ;
                        nxt_vfy_phase = 1'b0;
                        nxt_cmd_data  = frame(CMD_RDHW, RANGE_SEL_REG, 16'h0000);
                        nxt_cmd_rd    = 1'b0;
`else
                        nxt_state    = READY;
                        nxt_cfg_done = 1'b1;
`endif
                    end else begin
                        nxt_state    = CFG_REQ;
                        nxt_cmd_data = cfg_word(idx + 4'd1, RANGE_CODE);
                    end
                end
            end
`ifdef ADS_CFG_VERIFY_EN
            VFY_REQ: if (hs) nxt_state = VFY_WAIT;
            VFY_WAIT: begin
                if (spi_done && !vfy_phase) begin
                    nxt_state     = VFY_REQ;
                    nxt_vfy_phase = 1'b1;
                    nxt_cmd_data  = frame(CMD_NOP, 9'h000, 16'h0000);
                    nxt_cmd_rd    = 1'b1;
                end else if (spi_done && spi_rdata[3:0] == RANGE_CODE) begin
                    nxt_state    = READY;
                    nxt_cfg_done = 1'b1;
                    nxt_cmd_rd   = 1'b0;
                end else if (spi_done && int'(retry_cnt) < MAX_RETRY) begin
                    nxt_state     = CFG_REQ;
                    nxt_retry_cnt = retry_cnt + 4'd1;
                    nxt_idx       = 4'd0;
                    nxt_cmd_data  = cfg_word(4'd0, RANGE_CODE);
                    nxt_cmd_rd    = 1'b0;
                end else if (spi_done) begin
                    nxt_state    = IDLE;
                    nxt_cfg_err  = 1'b1;
                    nxt_cfg_done = 1'b0;
                    nxt_cmd_rd   = 1'b0;
                end
            end
`endif
            READY: begin
                if (pend || conv_req) begin
                    nxt_state    = RD_REQ;
                    nxt_pend     = pend && conv_req;
                    nxt_cmd_data = frame(CMD_NOP, 9'h000, 16'h0000);
                    nxt_cmd_rd   = 1'b1;
                end
            end
            RD_REQ: if (hs) nxt_state = RD_WAIT;
            RD_WAIT: begin
                if (spi_done) begin
                    nxt_state        = READY;
                    nxt_sample_data  = spi_rdata[31:16];
                    nxt_sample_valid = 1'b1;
                    nxt_cmd_rd       = 1'b0;
                end
            end
            default: nxt_state = IDLE;
        endcase

        if (restart) begin
            nxt_state    = CFG_REQ;
            nxt_idx      = 4'd0;
            nxt_pend     = 1'b0;
            nxt_cfg_done = 1'b0;
            nxt_cmd_data = cfg_word(4'd0, RANGE_CODE);
            nxt_cmd_rd   = 1'b0;
            if (state == READY) nxt_cfg_err = 1'b0;
`ifdef ADS_CFG_VERIFY_EN
            nxt_retry_cnt = 4'd0;
`endif
        end

        // A late spi_done on the expiring cycle still counts as on time.
        if (in_wait && !spi_done && tmo_expire) begin
            nxt_state    = IDLE;
            nxt_cfg_err  = 1'b1;
            nxt_cfg_done = 1'b0;
            nxt_pend     = 1'b0;
            nxt_cmd_rd   = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state        <= IDLE;
            idx          <= 4'd0;
            pend         <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_data     <= 32'h0;
            cmd_len      <= 6'd0;
            cmd_rd       <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            overrun      <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= 16'h0;
`ifdef ADS_CFG_VERIFY_EN
            vfy_phase    <= 1'b0;
            retry_cnt    <= 4'd0;
`endif
        end else begin
            state        <= nxt_state;
            idx          <= nxt_idx;
            pend         <= nxt_pend;
            cmd_valid    <= nxt_cmd_valid;
            cmd_data     <= nxt_cmd_data;
            cmd_len      <= FRAME_LEN;
            cmd_rd       <= nxt_cmd_rd;
            cfg_done     <= nxt_cfg_done;
            cfg_err      <= nxt_cfg_err;
            overrun      <= nxt_overrun;
            sample_valid <= nxt_sample_valid;
            sample_data  <= nxt_sample_data;
`ifdef ADS_CFG_VERIFY_EN
            vfy_phase    <= nxt_vfy_phase;
            retry_cnt    <= nxt_retry_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_ads_cfg_seq.sv
// tb/tb_ads_cfg_seq.sv - directed scoreboard bench for ads_cfg_seq
module tb_ads_cfg_seq;

    logic        clk_sys   = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        start     = 1'b0;
    logic        conv_req  = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        spi_done  = 1'b0;
    logic [31:0] spi_rdata = 32'h0;
    logic        cmd_valid, cmd_rd, cfg_done, cfg_err, overrun, sample_valid;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_len;
    logic [15:0] sample_data;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int frames_seen = 0, done_pulses = 0, sv_cycles = 0, hs_edge = 0;
    int stall_frame = -1, stall_left = 0, withhold_frame = -1, done_cnt = 0;
    logic [32:0] exp_frames[$];
    logic [15:0] exp_samples[$];

    ads_cfg_seq dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .start        (start),
        .conv_req     (conv_req),
        .cmd_ready    (cmd_ready),
        .spi_done     (spi_done),
        .spi_rdata    (spi_rdata),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .cmd_rd       (cmd_rd),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .overrun      (overrun),
        .sample_valid (sample_valid),
        .sample_data  (sample_data)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        case (i)
            0: return 32'hD000_0000;
            1: return 32'hD002_0000;
            2: return 32'hD014_0000;
            3: return 32'hD016_0000;
            4: return 32'hD010_0000;
            5: return 32'hD012_0000;
            default: return (i % 2 == 0) ? 32'hD014_0000 : 32'hD016_0000;
        endcase
    endfunction

    task automatic push_cfg(input int n, input bit with_vfy);
        for (int i = 0; i < n; i++) exp_frames.push_back({1'b0, exp_word(i)});
        if (with_vfy) begin
`ifdef ADS_CFG_VERIFY_EN
            exp_frames.push_back({1'b0, 32'hC814_0000});
            exp_frames.push_back({1'b1, 32'h0000_0000});
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_conv();
        conv_req = 1'b1; tick(); conv_req = 1'b0;
    endtask

    // SPI engine model: drives cmd_ready/spi_done, checks frames and samples against the scoreboard.
    initial begin
        forever begin
            @(posedge clk_sys); #2;
            if (!rst_sys_n) begin
                done_cnt = 0; spi_done = 1'b0; cmd_ready = 1'b1;
            end else begin
                spi_done = 1'b0;
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin spi_done = 1'b1; done_pulses++; end
                end
                if (sample_valid) begin
                    sv_cycles++;
                    chk("sample_expected", exp_samples.size() != 0, 1);
                    if (exp_samples.size() != 0) chk("sample_data", sample_data, exp_samples.pop_front());
                end
                cmd_ready = 1'b1;
                if (cmd_valid && frames_seen == stall_frame && stall_left > 0) begin
                    cmd_ready = 1'b0;
                    stall_left--;
                    if (exp_frames.size() != 0) chk("held_cmd_data", {cmd_rd, cmd_data}, exp_frames[0]);
                end
                if (cmd_valid && cmd_ready) begin
                    chk("frame_expected", exp_frames.size() != 0, 1);
                    if (exp_frames.size() != 0) chk("frame", {cmd_rd, cmd_data}, exp_frames.pop_front());
                    if (frames_seen != withhold_frame) done_cnt = 3;
                    frames_seen++;
                    hs_edge = cyc + 1;
                end
            end
        end
    end

    initial begin
        int h0, sv0;
        repeat (3) tick();
        chk("rst_flags", {cmd_valid, cmd_rd, cfg_done, cfg_err, overrun, sample_valid, cmd_len}, 0);
        chk("rst_data", {cmd_data, sample_data}, 0);
        rst_sys_n = 1'b1;
        tick();
        chk("cmd_len", cmd_len, 32);

        pulse_conv();
        repeat (10) tick();
        chk("conv_ignored_unconfigured", frames_seen, 0);

        // Full configuration with a 5-cycle ready stall on frame 3.
        stall_frame = 3; stall_left = 5;
        push_cfg(8, 1'b1);
        pulse_start();
        for (int i = 0; i < 600 && !cfg_done; i++) tick();
        chk("cfg_done", cfg_done, 1);
        chk("cfg_done_on_last_spi_done", spi_done, 1);
        chk("cfg_sb_empty", exp_frames.size(), 0);
        chk("stall_consumed", stall_left, 0);

        // Single conversion read.
        spi_rdata = 32'h7FFF_0000;
        exp_frames.push_back({1'b1, 32'h0});
        exp_samples.push_back(16'h7FFF);
        sv0 = sv_cycles;
        pulse_conv();
        for (int i = 0; i < 30 && sv_cycles == sv0; i++) tick();
        repeat (5) tick();
        chk("single_sample_pulse", sv_cycles - sv0, 1);
        chk("sample_hold", sample_data, 16'h7FFF);

        // Three requests during one RD_WAIT: one serviced later, rest overrun.
        spi_rdata = 32'h1234_0000;
        repeat (2) begin
            exp_frames.push_back({1'b1, 32'h0});
            exp_samples.push_back(16'h1234);
        end
        h0 = frames_seen; sv0 = sv_cycles;
        pulse_conv();
        for (int i = 0; i < 20 && frames_seen == h0; i++) tick();
        conv_req = 1'b1;
        repeat (3) tick();
        conv_req = 1'b0;
        repeat (40) tick();
        chk("overrun", overrun, 1);
        chk("extra_read_frames", frames_seen - h0, 2);
        chk("extra_read_samples", sv_cycles - sv0, 2);
        chk("read_sb_empty", exp_frames.size() + exp_samples.size(), 0);

        // spi_done withheld after frame 4 of a restarted configuration.
        spi_rdata = 32'h0;
        withhold_frame = frames_seen + 4;
        push_cfg(5, 1'b0);
        pulse_start();
        for (int i = 0; i < 1500 && !cfg_err; i++) tick();
        chk("tmo_cfg_err", cfg_err, 1);
        chk("tmo_latency", cyc - hs_edge, 1000);
        chk("tmo_outputs", {cfg_done, cmd_valid}, 0);
        chk("tmo_sb_empty", exp_frames.size(), 0);

        // From IDLE a new start reconfigures; a start mid-configuration is ignored.
        withhold_frame = -1;
        push_cfg(8, 1'b1);
        pulse_start();
        repeat (20) tick();
        pulse_start();
        for (int i = 0; i < 600 && !cfg_done; i++) tick();
        chk("reconfig_done", cfg_done, 1);
        chk("cfg_err_sticky", cfg_err, 1);
        repeat (3) tick();
        chk("reconfig_sb_empty", exp_frames.size(), 0);

        // Reset in the middle of a read frame.
        exp_frames.push_back({1'b1, 32'h0});
        h0 = frames_seen; sv0 = sv_cycles;
        pulse_conv();
        for (int i = 0; i < 20 && frames_seen == h0; i++) tick();
        rst_sys_n = 1'b0;
        #1;
        chk("midrst_flags", {cmd_valid, cmd_rd, cfg_done, cfg_err, overrun, sample_valid}, 0);
        repeat (3) tick();
        rst_sys_n = 1'b1;
        repeat (10) tick();
        chk("midrst_no_sample", sv_cycles - sv0, 0);
        chk("midrst_no_frame", frames_seen - h0, 1);

`ifdef ADS_CFG_VERIFY_EN
        // Range readback mismatch: initial pass plus three retries, then error.
        spi_rdata = 32'h0000_0005;
        h0 = frames_seen;
        repeat (4) push_cfg(8, 1'b1);
        pulse_start();
        for (int i = 0; i < 3000 && !cfg_err; i++) tick();
        repeat (10) tick();
        chk("vfy_cfg_err", cfg_err, 1);
        chk("vfy_cfg_done", cfg_done, 0);
        chk("vfy_frames", frames_seen - h0, 40);
        chk("vfy_sb_empty", exp_frames.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
